// File: rtl/sync_fifo_lvl_if.sv
// Handshake/status bundle between sync_fifo_lvl and its producer/consumer side.
// slave = FIFO side, master = the stage driving writes/reads and watching status.
interface sync_fifo_lvl_if #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 8
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              clr_err;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, clr_err, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Level-reporting sync FIFO, any DEPTH>=2; read data 1 cycle after rd_en, or 0 cycles with SYNC_FIFO_LVL_FWFT_EN.
// Backpressure: writes refused when full unless a read is accepted the same cycle; refused ops set sticky flags.
module sync_fifo_lvl #(
    parameter int DEPTH     = 32,
    parameter int DATA_W    = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sync_fifo_lvl_if.slave fifo_if
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              full, empty;
    logic              rd_acc, wr_acc;

    assign full  = (count_q == LVL_FULL);
    assign empty = (count_q == '0);

    // No empty-bypass: a read on empty is refused even if a write lands this cycle.
    assign rd_acc = !fifo_if.flush && fifo_if.rd_en && !empty;
    assign wr_acc = !fifo_if.flush && fifo_if.wr_en && (!full || rd_acc);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fifo_if.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // A set event wins over a coincident clr_err; flush masks set events.
    always_comb begin
        ovf_d = ovf_q && !fifo_if.clr_err;
        unf_d = unf_q && !fifo_if.clr_err;
        if (!fifo_if.flush && fifo_if.wr_en && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (!fifo_if.flush && fifo_if.rd_en && !rd_acc) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= fifo_if.din;
        end
    end

`ifdef SYNC_FIFO_LVL_FWFT_EN
    assign fifo_if.dout       = empty ? '0 : mem_q[rptr_q];
    assign fifo_if.dout_valid = !empty;
`else
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    // rd_acc is already low during flush, so flush also clears dout_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem_q[rptr_q];
            end
        end
    end

    assign fifo_if.dout       = dout_q;
    assign fifo_if.dout_valid = dout_valid_q;
`endif

    assign fifo_if.full         = full;
    assign fifo_if.empty        = empty;
    assign fifo_if.almost_full  = (count_q >= LVL_AF);
    assign fifo_if.almost_empty = (count_q <= LVL_AE);
    assign fifo_if.level        = count_q;
    assign fifo_if.overflow     = ovf_q;
    assign fifo_if.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Scoreboard bench for sync_fifo_lvl at DEPTH=5, AFULL_TH=3, AEMPTY_TH=2.
// Works in either read mode (SYNC_FIFO_LVL_FWFT_EN defined or not).
module tb_sync_fifo_lvl;
    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int AF    = 3;
    localparam int AE    = 2;

    logic clk;
    logic rst_n;

    sync_fifo_lvl_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

    sync_fifo_lvl #(
        .DEPTH(DEPTH), .DATA_W(DW), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_if(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input bit racc);
        int lvl;
        lvl = m_fifo.size();
        chk("level",        32'(bus.level),        32'(lvl));
        chk("full",         32'(bus.full),         32'(lvl == DEPTH));
        chk("empty",        32'(bus.empty),        32'(lvl == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(lvl >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(lvl <= AE));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
`ifdef SYNC_FIFO_LVL_FWFT_EN
        chk("dout_valid",   32'(bus.dout_valid),   32'(lvl != 0));
`else
        chk("dout_valid",   32'(bus.dout_valid),   32'(racc));
`endif
    endtask

    task automatic check_reset();
        chk("rst_level",        32'(bus.level),        32'd0);
        chk("rst_empty",        32'(bus.empty),        32'd1);
        chk("rst_full",         32'(bus.full),         32'd0);
        chk("rst_almost_full",  32'(bus.almost_full),  32'd0);
        chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
        chk("rst_overflow",     32'(bus.overflow),     32'd0);
        chk("rst_underflow",    32'(bus.underflow),    32'd0);
        chk("rst_dout",         32'(bus.dout),         32'd0);
        chk("rst_dout_valid",   32'(bus.dout_valid),   32'd0);
    endtask

    // Drive one cycle of stimulus, advance the reference model, then check after the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit fl, input bit ce);
        bit racc;
        bit wacc;
        int lvl;
        bus.wr_en   = w;
        bus.din     = d;
        bus.rd_en   = r;
        bus.flush   = fl;
        bus.clr_err = ce;
        lvl  = m_fifo.size();
        racc = !fl && r && (lvl != 0);
        wacc = !fl && w && ((lvl < DEPTH) || racc);
        m_ovf = (m_ovf && !ce) || (!fl && w && !wacc);
        m_unf = (m_unf && !ce) || (!fl && r && !racc);
        if (fl) begin
            m_fifo.delete();
        end else begin
            if (racc) exp_q.push_back(m_fifo.pop_front());
            if (wacc) m_fifo.push_back(d);
        end
        @(posedge clk);
        #1;
        check_state(racc);
    endtask

    // Output side of the scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef SYNC_FIFO_LVL_FWFT_EN
            if (bus.rd_en && bus.dout_valid && !bus.flush) begin
`else
            if (bus.dout_valid) begin
`endif
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.din     = '0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        #3;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 1..5, then one write too many.
        for (int i = 1; i <= DEPTH; i++) step(1, DW'(i), 0, 0, 0);
        step(1, 8'h06, 0, 0, 0);

        // Drain 1..5, then one read too many.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Pointer wrap: 12 words with level held between 1 and 3.
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'h01, 0, 0, 0);
        for (int i = 2; i < 12; i++) step(1, DW'(i), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full plus simultaneous read and write.
        for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h10 + i), 0, 0, 0);
        step(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Empty plus simultaneous read and write, then clear; then set coincident with clear.
        step(1, 8'h33, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush at level 3 with wr_en high and overflow already set.
        for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h40 + i), 0, 0, 0);
        step(1, 8'h45, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 8'h99, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);

`ifdef SYNC_FIFO_LVL_FWFT_EN
        step(1, 8'h5C, 0, 0, 0);
        chk("fwft_head", 32'(bus.dout), 32'h5C);
        step(0, 0, 1, 0, 0);
`else
        step(1, 8'h5C, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("std_dout_after_pop", 32'(bus.dout), 32'h5C);
`endif

        // Random traffic with occasional flush and error clear.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), DW'($urandom),
                 bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h70 + i), 0, 0, 0);
        step(1, 8'h75, 1, 0, 0);
        step(1, 8'h76, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        m_fifo.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_reset();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'h81, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
